snake_body_tracker: RTL
=======================

Name: snake_body_tracker

Overview:
- Read side of the snake body FIFO. The movement controller pushes each new head position {x,y} into the FIFO. This block pops the oldest entry (the tail) on every non-growing step.
- Maintains the 16x8 pixel map: sets the head pixel, clears the tail pixel, and detects wall and self collisions.
- Sits between the body FIFO and the LED-matrix scanner. The scanner reads one pixel row at a time.

Parameters:
- INIT_LEN, 3, number of initial steps treated as growth; sets the starting snake length.
- MAX_LEN, 128, FIFO depth; length saturates here.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- step  in  1  one-cycle pulse: head moved and was pushed into the FIFO this cycle
- head_x  in  4  new head column, 0..15
- head_y  in  4  new head row, 0..7 valid
- grow  in  1  food eaten on this step; sampled with step
- fifo_q  in  8  FIFO read data {x,y}; normal (non-show-ahead) mode, valid the cycle after rdreq
- fifo_empty  in  1  FIFO empty flag
- fifo_rdreq  out  1  FIFO pop request
- row_sel  in  3  pixel row select for the scanner
- row_data  out  16  selected row; bit = 0 means lit (active-low LEDs)
- length  out  8  current body length
- busy  out  1  update in progress
- hit  out  1  one-cycle collision pulse
- game_over  out  1  sticky collision flag
- err  out  2  sticky flags: [0] step while busy (overrun), [1] pop on empty FIFO (underflow)

Behaviour:
- Reset values:
  - all map rows 16'hFFFF; length = 0
  - fifo_rdreq, busy, hit, game_over, err all 0
  - FSM in IDLE
  - Reset mid-update aborts immediately.
- States:
  - IDLE -> HEAD when step && !game_over, if effective grow: grow || length < INIT_LEN, and length < MAX_LEN.
  - IDLE -> POP on step otherwise.
  - POP -> WAIT -> CLEAR -> HEAD -> IDLE.
  - HEAD -> IDLE.
  - head_x/head_y and grow are latched on the step cycle.
- POP: assert fifo_rdreq for exactly one cycle. If fifo_empty, do not assert it; set err[1] and skip to HEAD.
- CLEAR: set map bit at (fifo_q[7:4], fifo_q[3:0]) to 1 (off).
- HEAD:
  - If head_y > 7, raise a wall hit.
  - Otherwise, if the head pixel is already lit, raise a self hit. Clearing the tail first makes moving into the vacated tail cell legal.
  - Then clear the head bit (lit) when in range.
  - length++ on the effective-grow path only.
- hit: pulses in the cycle after HEAD. game_over is set in the same cycle and held until reset.
- Latency, step at cycle t:
  - Non-grow: fifo_rdreq at t+1, q used at t+3, head at t+4, busy low at t+5.
  - Grow: head at t+1, busy low at t+2.
  - busy is high in every non-IDLE state.
- step while busy: ignored; set err[0].
- step after game_over: ignored; no error.
- row_data: combinational from the map, indexed by row_sel. Updates are visible the cycle after a write.
- length never exceeds MAX_LEN. Growth at MAX_LEN behaves as a normal move.

Optional Feature:
- Macro: SNAKE_SELF_HIT_EN.
- Defined: self-collision check as above.
- Undefined: only wall hits raise hit/game_over. Overlapping the body is allowed, and the pixel simply stays lit.

Decomposition:
- Package snake_pkg holds:
  - GRID_W = 16, GRID_H = 8
  - pos_t: 8-bit packed {x[3:0], y[3:0]}
  - tracker state enum: IDLE, POP, WAIT, CLEAR, HEAD
  - err bit indices
- Sub-module snake_pixel_map: 8x16 register file.
  - One bit-set port and one bit-clear port (same cycle allowed; set wins on the same bit).
  - One asynchronous row read port plus one pixel read, for the HEAD check.

Test Plan:
- Reset, then sample all rows -> every row_data = 16'hFFFF, length = 0, busy = 0, err = 0.
- INIT_LEN=3, steps at (0,0), (1,0), (2,0) with FIFO fed -> row 0 = 16'hFFF8, length = 3, no fifo_rdreq.
- Fourth step to (3,0), FIFO q = 8'h00 -> rdreq at t+1, row 0 = 16'hFFF1, length = 3, busy low at t+5.
- Step with head_y = 8 -> hit pulse, game_over = 1; later steps are ignored and row data is unchanged.
- Length 4 forming a loop, head steps into the lit non-tail cell -> hit when SNAKE_SELF_HIT_EN is defined; no hit when undefined.
- Step at t+2 of an update -> err[0] = 1, update completes normally. Non-grow step with fifo_empty = 1 -> err[1] = 1, no rdreq.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake body tracker: grid size, packed position, FSM states, err bits.
// Pure declarations; no logic.
package snake_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 8;

    localparam int ERR_OVERRUN   = 0;
    localparam int ERR_UNDERFLOW = 1;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        CLEAR,
        HEAD
    } state_t;

    function automatic logic in_grid(input pos_t p);
        return p.y < 4'(GRID_H);
    endfunction

endpackage

// File: rtl/snake_pixel_map.sv
// 8x16 pixel register file, bit 0 = lit; one set (off) and one clear (lit) port, set wins.
// Writes visible the cycle after; row and pixel reads are combinational.
// No backpressure: writes are accepted every cycle.
module snake_pixel_map
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic [3:0]  set_x,
    input  logic [2:0]  set_y,
    input  logic        clr_en,
    input  logic [3:0]  clr_x,
    input  logic [2:0]  clr_y,
    input  logic [2:0]  row_sel,
    output logic [15:0] row_data,
    input  logic [3:0]  pix_x,
    input  logic [2:0]  pix_y,
    output logic        pix_lit
);

    logic [GRID_H-1:0][GRID_W-1:0] map_q;
    logic [GRID_H-1:0][GRID_W-1:0] map_d;

    always_comb begin
        map_d = map_q;
        for (int r = 0; r < GRID_H; r++) begin
            if (clr_en && clr_y == r[2:0]) map_d[r][clr_x] = 1'b0;
            if (set_en && set_y == r[2:0]) map_d[r][set_x] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            map_q <= '1;
        end else begin
            map_q <= map_d;
        end
    end

    assign row_data = map_q[row_sel];
    assign pix_lit  = ~map_q[pix_y][pix_x];

endmodule

// File: rtl/snake_body_tracker.sv
// Pops the body FIFO tail, maintains the pixel map, flags wall/self collisions (self check under SNAKE_SELF_HIT_EN).
// Latency: grow step done in 2 cycles, normal step in 5 (rdreq at +1, q used at +3, head at +4).
// No backpressure: steps arriving while busy are dropped and flagged in err[0].
module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic [3:0]  head_x,
    input  logic [3:0]  head_y,
    input  logic        grow,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    input  logic [2:0]  row_sel,
    output logic [15:0] row_data,
    output logic [7:0]  length,
    output logic        busy,
    output logic        hit,
    output logic        game_over,
    output logic [1:0]  err
);

`ifdef SNAKE_SELF_HIT_EN
    localparam logic SELF_HIT_EN = 1'b1;
`else
    localparam logic SELF_HIT_EN = 1'b0;
`endif

    localparam logic [7:0] INIT_LEN_L = 8'(INIT_LEN);
    localparam logic [7:0] MAX_LEN_L  = 8'(MAX_LEN);

    state_t      state_q, state_d;
    pos_t        head_q, head_d;
    logic        grow_q, grow_d;
    logic [7:0]  length_q, length_d;
    logic        hit_q, hit_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  err_q, err_d;

    pos_t        tail;
    logic        eff_grow;
    logic        pix_lit;
    logic        head_collide;
    logic        map_set;
    logic        map_clr;

    assign tail     = pos_t'(fifo_q);
    assign eff_grow = (grow || length_q < INIT_LEN_L) && length_q < MAX_LEN_L;
    // The tail was already cleared in CLEAR, so stepping into the vacated cell reads as unlit.
    assign head_collide = !in_grid(head_q) || (SELF_HIT_EN && pix_lit);

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        grow_d      = grow_q;
        length_d    = length_q;
        hit_d       = 1'b0;
        game_over_d = game_over_q;
        err_d       = err_q;
        fifo_rdreq  = 1'b0;
        map_set     = 1'b0;
        map_clr     = 1'b0;

        if (step && state_q != IDLE) err_d[ERR_OVERRUN] = 1'b1;

        case (state_q)
            IDLE: begin
                if (step && !game_over_q) begin
                    head_d.x = head_x;
                    head_d.y = head_y;
                    grow_d   = eff_grow;
                    state_d  = eff_grow ? HEAD : POP;
                end
            end
            POP: begin
                if (fifo_empty) begin
                    err_d[ERR_UNDERFLOW] = 1'b1;
                    state_d              = HEAD;
                end else begin
                    fifo_rdreq = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                state_d = CLEAR;
            end
            CLEAR: begin
                map_set = in_grid(tail);
                state_d = HEAD;
            end
            HEAD: begin
                if (head_collide) begin
                    hit_d       = 1'b1;
                    game_over_d = 1'b1;
                end
                map_clr = in_grid(head_q);
                if (grow_q) length_d = length_q + 8'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            grow_q      <= 1'b0;
            length_q    <= '0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            grow_q      <= grow_d;
            length_q    <= length_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
            err_q       <= err_d;
        end
    end

    snake_pixel_map u_map (
        .clk      (clk),
        .reset    (reset),
        .set_en   (map_set),
        .set_x    (tail.x),
        .set_y    (tail.y[2:0]),
        .clr_en   (map_clr),
        .clr_x    (head_q.x),
        .clr_y    (head_q.y[2:0]),
        .row_sel  (row_sel),
        .row_data (row_data),
        .pix_x    (head_q.x),
        .pix_y    (head_q.y[2:0]),
        .pix_lit  (pix_lit)
    );

    assign busy      = state_q != IDLE;
    assign length    = length_q;
    assign hit       = hit_q;
    assign game_over = game_over_q;
    assign err       = err_q;

endmodule
